wfq_flow_service_meter: RTL and testbench
=========================================

// Module: wfq_flow_service_meter
// PURPOSE
//   Synthesizable per-flow service meter for the WFQ scheduler output. It taps
//   the dequeue path (read request plus data word out of WFQ_top), tags each
//   served word by flow ID and accumulates the bytes served per flow over a
//   measurement window. It replaces ad-hoc bench counting with on-chip
//   statistics. Sits beside WFQ_top; it observes only and never back-pressures.
// PARAMETERS
//   NUM_FLOWS     16   flows metered; flow ID = data word bits [FLOW_ID_W-1:0]
//   FLOW_ID_W     13   width of the flow-ID field inside the data word
//   DATA_W        64   scheduler output data width
//   RD_LATENCY    7    cycles from in_rd_packet_req to valid data word (>=1)
//   WORD_BYTES    8    bytes credited per served word
//   CNT_W         32   width of each byte counter (saturating)
//   WINDOW_WORDS  0    words per window; 0 = unbounded (stop by in_stop only)
//   SEL_W         $clog2(NUM_FLOWS+2)  readback select width (derived)
// PORTS
//   clk               in   1          clock
//   rst               in   1          asynchronous reset, active-low
//   in_rd_packet_req  in   1          read strobe issued to the scheduler
//   in_packet_data    in   DATA_W     scheduler data out (out_packet_data_out)
//   in_start          in   1          pulse: clear all counters, open window
//   in_stop           in   1          pulse: close window, freeze counters
//   in_rd_sel         in   SEL_W      readback select
//   in_rd_en          in   1          readback strobe
//   out_rd_count      out  CNT_W      readback value
//   out_rd_valid      out  1          out_rd_count valid (1 cycle after in_rd_en)
//   out_running       out  1          state == RUN
//   out_window_done   out  1          state == DONE
// BEHAVIOUR
//   Reset (rst=0, async): all counters, delay line and outputs 0; state IDLE.
//   Delay line: RD_LATENCY-deep shift of in_rd_packet_req; sample_v = tap at
//     depth RD_LATENCY (sample_v high exactly RD_LATENCY cycles after the req).
//   FSM IDLE -> RUN on in_start; RUN -> DONE on in_stop or window full;
//     DONE -> RUN on in_start. in_start in RUN restarts (clears, stays RUN).
//     in_start and in_stop in the same cycle: in_start wins.
//   Counting (RUN only, on sample_v):
//     - id = in_packet_data[FLOW_ID_W-1:0]; hit if all higher data bits are 0
//       and id < NUM_FLOWS -> cnt[id] += WORD_BYTES;
//       otherwise miss_cnt += 1 (words).
//     - total += WORD_BYTES on every sample; word_cnt += 1.
//     - All counters saturate at 2^CNT_W-1; no wrap.
//   Window: WINDOW_WORDS != 0 and word_cnt reaches WINDOW_WORDS -> DONE on the
//     next edge; the sample that reaches the limit is counted, no later ones.
//   Clear on in_start: counters zeroed in that edge; a sample_v in the same
//     cycle is discarded; the delay line is NOT flushed (in-flight reads issued
//     before start are counted if they land in RUN).
//   IDLE/DONE: sample_v ignored; counters hold.
//   Readback: registered, 1-cycle latency, legal in any state.
//     in_rd_sel < NUM_FLOWS -> cnt[sel]; == NUM_FLOWS -> total;
//     == NUM_FLOWS+1 -> miss_cnt; larger -> 0. Read and update in the same
//     cycle return the pre-update value. out_rd_valid = in_rd_en delayed 1.
//   Reset mid-window: all state lost, returns to IDLE; no partial results.
// TESTING
//   1. Reset, start, 16 flows x 2 words each read back -> cnt[f]=16 for all f,
//      total=256, miss=0.
//   2. Flow 0 sends 3-word, flows 1..15 2-word packets, 128 rounds, drain ->
//      cnt[0]=3072, cnt[1..15]=2048 each, total=33792.
//   3. WINDOW_WORDS=10, 12 reads -> out_window_done after 10th sample;
//      total=80; 11th/12th not counted.
//   4. Data word 0x10 (id 16) and 0x1_0000_0003 -> miss=2; cnt[0] and
//      cnt[3] unchanged.
//   5. CNT_W=8: 40 words to flow 5 -> cnt[5]=255 (saturated), not 64.
//   6. in_start and in_stop same cycle in DONE -> RUN, counters 0; rst low
//      mid-RUN -> all reads 0, out_running=0.

Source files
------------

// File: rtl/wfq_flow_service_meter.sv
// Per-flow byte meter tapping the WFQ dequeue path; observe-only, never back-pressures.
// Counting happens RD_LATENCY cycles after each read strobe; readback is registered with 1-cycle latency.
module wfq_flow_service_meter #(
  parameter int NUM_FLOWS    = 16,
  parameter int FLOW_ID_W    = 13,
  parameter int DATA_W       = 64,
  parameter int RD_LATENCY   = 7,
  parameter int WORD_BYTES   = 8,
  parameter int CNT_W        = 32,
  parameter int WINDOW_WORDS = 0,
  parameter int SEL_W        = $clog2(NUM_FLOWS + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_rd_packet_req,
  input  logic [DATA_W-1:0] in_packet_data,
  input  logic              in_start,
  input  logic              in_stop,
  input  logic [SEL_W-1:0]  in_rd_sel,
  input  logic              in_rd_en,
  output logic [CNT_W-1:0]  out_rd_count,
  output logic              out_rd_valid,
  output logic              out_running,
  output logic              out_window_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] WIN_LIM = CNT_W'(WINDOW_WORDS);
  localparam logic [CNT_W-1:0] BYTES   = CNT_W'(WORD_BYTES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t                state;
  state_t                state_nxt;
  logic [RD_LATENCY-1:0] req_dly;
  logic                  sample_v;
  logic                  win_full;
  logic                  count_en;
  logic                  id_hit;
  logic [FLOW_ID_W-1:0]  flow_id;
  logic [CNT_W-1:0]      cnt [NUM_FLOWS];
  logic [CNT_W-1:0]      total;
  logic [CNT_W-1:0]      miss_cnt;
  logic [CNT_W-1:0]      word_cnt;
  logic [CNT_W-1:0]      rd_mux;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  // Delay line is deliberately not flushed by in_start: reads already in flight still land.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_dly <= '0;
    end else begin
      req_dly[0] <= in_rd_packet_req;
      for (int i = 1; i < RD_LATENCY; i++) begin
        req_dly[i] <= req_dly[i-1];
      end
    end
  end

  assign sample_v = req_dly[RD_LATENCY-1];
  assign flow_id  = in_packet_data[FLOW_ID_W-1:0];
  assign id_hit   = (in_packet_data[DATA_W-1:FLOW_ID_W] == '0) &&
                    (flow_id < FLOW_ID_W'(NUM_FLOWS));
  // Once the window limit is reached no further samples are taken, even before DONE lands.
  assign win_full = (WINDOW_WORDS != 0) && (word_cnt >= WIN_LIM);
  assign count_en = (state == RUN) && sample_v && !in_start && !win_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_start) state_nxt = RUN;
      RUN: begin
        if (in_start)                 state_nxt = RUN;
        else if (in_stop || win_full) state_nxt = DONE;
      end
      DONE:    if (in_start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_running     = (state == RUN);
    out_window_done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int f = 0; f < NUM_FLOWS; f++) cnt[f] <= '0;
      total    <= '0;
      miss_cnt <= '0;
      word_cnt <= '0;
    end else if (in_start) begin
      for (int f = 0; f < NUM_FLOWS; f++) cnt[f] <= '0;
      total    <= '0;
      miss_cnt <= '0;
      word_cnt <= '0;
    end else if (count_en) begin
      total    <= sat_add(total, BYTES);
      word_cnt <= sat_add(word_cnt, ONE);
      if (id_hit) begin
        for (int f = 0; f < NUM_FLOWS; f++) begin
          if (flow_id == FLOW_ID_W'(f)) cnt[f] <= sat_add(cnt[f], BYTES);
        end
      end else begin
        miss_cnt <= sat_add(miss_cnt, ONE);
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (in_rd_sel == SEL_W'(NUM_FLOWS)) begin
      rd_mux = total;
    end else if (in_rd_sel == SEL_W'(NUM_FLOWS + 1)) begin
      rd_mux = miss_cnt;
    end else begin
      for (int f = 0; f < NUM_FLOWS; f++) begin
        if (in_rd_sel == SEL_W'(f)) rd_mux = cnt[f];
      end
    end
  end

  // Sampled from the current registers, so a read racing an update returns the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_rd_count <= '0;
      out_rd_valid <= 1'b0;
    end else begin
      out_rd_valid <= in_rd_en;
      if (in_rd_en) out_rd_count <= rd_mux;
    end
  end

endmodule

// File: tb/tb_wfq_flow_service_meter.sv
// Bench: three meter instances (unbounded, 10-word window, 8-bit counters) share one stimulus
// stream; a queue-based reference model is compared against every cycle.
module tb_wfq_flow_service_meter;

  localparam int NI = 3;
  localparam int L  = 7;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_rd_packet_req;
  logic [63:0] in_packet_data;
  logic        in_start;
  logic        in_stop;
  logic [4:0]  in_rd_sel;
  logic        in_rd_en;

  logic [31:0] cnt_m, cnt_w;
  logic [7:0]  cnt_s;
  logic        vld_m, vld_w, vld_s;
  logic        run_m, run_w, run_s;
  logic        done_m, done_w, done_s;

  always #5 clk = ~clk;

  wfq_flow_service_meter u_main (
    .clk(clk), .rst(rst), .in_rd_packet_req(in_rd_packet_req), .in_packet_data(in_packet_data),
    .in_start(in_start), .in_stop(in_stop), .in_rd_sel(in_rd_sel), .in_rd_en(in_rd_en),
    .out_rd_count(cnt_m), .out_rd_valid(vld_m), .out_running(run_m), .out_window_done(done_m));

  wfq_flow_service_meter #(.WINDOW_WORDS(10)) u_win (
    .clk(clk), .rst(rst), .in_rd_packet_req(in_rd_packet_req), .in_packet_data(in_packet_data),
    .in_start(in_start), .in_stop(in_stop), .in_rd_sel(in_rd_sel), .in_rd_en(in_rd_en),
    .out_rd_count(cnt_w), .out_rd_valid(vld_w), .out_running(run_w), .out_window_done(done_w));

  wfq_flow_service_meter #(.CNT_W(8)) u_sat (
    .clk(clk), .rst(rst), .in_rd_packet_req(in_rd_packet_req), .in_packet_data(in_packet_data),
    .in_start(in_start), .in_stop(in_stop), .in_rd_sel(in_rd_sel), .in_rd_en(in_rd_en),
    .out_rd_count(cnt_s), .out_rd_valid(vld_s), .out_running(run_s), .out_window_done(done_s));

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic longint dut_cnt(input int k);
    case (k)
      0:       return longint'(cnt_m);
      1:       return longint'(cnt_w);
      default: return longint'(cnt_s);
    endcase
  endfunction

  function automatic longint dut_vld(input int k);
    case (k)
      0:       return longint'(vld_m);
      1:       return longint'(vld_w);
      default: return longint'(vld_s);
    endcase
  endfunction

  function automatic longint dut_run(input int k);
    case (k)
      0:       return longint'(run_m);
      1:       return longint'(run_w);
      default: return longint'(run_s);
    endcase
  endfunction

  function automatic longint dut_done(input int k);
    case (k)
      0:       return longint'(done_m);
      1:       return longint'(done_w);
      default: return longint'(done_s);
    endcase
  endfunction

  // ---------------- reference model ----------------
  int     win_w[NI] = '{0, 10, 0};
  longint maxv[NI]  = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 255};
  int     mst[NI];
  longint mcnt[NI][16];
  longint mtot[NI], mmiss[NI], mwords[NI], mrd[NI];
  bit     mrv[NI];
  bit     hist[$];

  function automatic longint sat(input longint v, input longint m);
    return (v > m) ? m : v;
  endfunction

  function automatic longint rb(input int k, input int sel);
    if (sel < 16)  return mcnt[k][sel];
    if (sel == 16) return mtot[k];
    if (sel == 17) return mmiss[k];
    return 0;
  endfunction

  function automatic void mclear(input int k);
    for (int f = 0; f < 16; f++) mcnt[k][f] = 0;
    mtot[k] = 0; mmiss[k] = 0; mwords[k] = 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    bit          smp;
    bit          full;
    logic [63:0] d;
    if (!rst) begin
      hist.delete();
      for (int k = 0; k < NI; k++) begin
        mclear(k);
        mst[k] = M_IDLE; mrd[k] = 0; mrv[k] = 0;
      end
    end else begin
      hist.push_front(in_rd_packet_req);
      smp = (hist.size() > L) ? hist[L] : 1'b0;
      if (hist.size() > L + 1) void'(hist.pop_back());
      d = in_packet_data;
      for (int k = 0; k < NI; k++) begin
        if (in_rd_en) mrd[k] = rb(k, int'(in_rd_sel));
        mrv[k] = in_rd_en;
        full = (win_w[k] != 0) && (mwords[k] >= win_w[k]);
        if (in_start) begin
          mclear(k);
          mst[k] = M_RUN;
        end else if (mst[k] == M_RUN) begin
          if (smp && !full) begin
            if (d[63:13] == 0 && d[12:0] < 16) mcnt[k][d[3:0]] = sat(mcnt[k][d[3:0]] + 8, maxv[k]);
            else                               mmiss[k] = sat(mmiss[k] + 1, maxv[k]);
            mtot[k]   = sat(mtot[k] + 8, maxv[k]);
            mwords[k] = mwords[k] + 1;
          end
          if (in_stop || full) mst[k] = M_DONE;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("running[%0d]", k), dut_run(k), longint'(mst[k] == M_RUN));
      chk($sformatf("window_done[%0d]", k), dut_done(k), longint'(mst[k] == M_DONE));
      chk($sformatf("rd_valid[%0d]", k), dut_vld(k), longint'(mrv[k]));
      if (mrv[k]) chk($sformatf("rd_count[%0d]", k), dut_cnt(k), mrd[k]);
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {longint due; logic [63:0] d;} pend_t;
  pend_t  pend[$];
  longint tnow = 0;

  // Emulates the scheduler: data for a read appears L intervals after its strobe.
  task automatic step(input bit req, input logic [63:0] d, input bit st = 0, input bit sp = 0,
                      input bit re = 0, input int sel = 0);
    pend_t p;
    in_packet_data = {$urandom, $urandom};
    while (pend.size() > 0 && pend[0].due < tnow) void'(pend.pop_front());
    if (pend.size() > 0 && pend[0].due == tnow) begin
      in_packet_data = pend[0].d;
      void'(pend.pop_front());
    end
    if (req) begin
      p.due = tnow + L; p.d = d;
      pend.push_back(p);
    end
    in_rd_packet_req = req;
    in_start  = st;
    in_stop   = sp;
    in_rd_en  = re;
    in_rd_sel = 5'(sel);
    @(posedge clk);
    #1;
    tnow++;
  endtask

  task automatic drain();
    repeat (L + 2) step(0, '0);
  endtask

  task automatic rdchk(input int sel, input longint e0, input longint e1, input longint e2,
                       input string nm);
    step(0, '0, 0, 0, 1, sel);
    chk({nm, "/main"}, longint'(cnt_m), e0);
    chk({nm, "/win"},  longint'(cnt_w), e1);
    chk({nm, "/sat"},  longint'(cnt_s), e2);
  endtask

  initial begin
    logic [63:0] d;
    int          r;
    rst = 1'b0;
    in_rd_packet_req = 1'b0; in_packet_data = '0; in_start = 1'b0; in_stop = 1'b0;
    in_rd_sel = '0; in_rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // reset state
    chk("reset_running", longint'(run_m), 0);
    chk("reset_done", longint'(done_m), 0);
    rdchk(16, 0, 0, 0, "reset_total");

    // 16 flows x 2 words
    step(0, '0, 1);
    for (int f = 0; f < 16; f++) repeat (2) step(1, 64'(f));
    drain();
    for (int f = 0; f < 16; f++) rdchk(f, 16, (f < 5) ? 16 : 0, 16, $sformatf("t1_cnt%0d", f));
    rdchk(16, 256, 80, 255, "t1_total");
    rdchk(17, 0, 0, 0, "t1_miss");

    // flow 0 three words, others two, 128 rounds
    step(0, '0, 1);
    for (int rnd = 0; rnd < 128; rnd++) begin
      repeat (3) step(1, 64'd0);
      for (int f = 1; f < 16; f++) repeat (2) step(1, 64'(f));
    end
    drain();
    rdchk(0, 3072, 24, 255, "t2_cnt0");
    rdchk(1, 2048, 16, 255, "t2_cnt1");
    rdchk(15, 2048, 0, 255, "t2_cnt15");
    rdchk(16, 33792, 80, 255, "t2_total");

    // window of 10 with 12 reads
    step(0, '0, 1);
    repeat (12) step(1, 64'd7);
    drain();
    chk("t3_win_done", longint'(done_w), 1);
    chk("t3_main_running", longint'(run_m), 1);
    rdchk(16, 96, 80, 96, "t3_total");
    rdchk(7, 96, 80, 96, "t3_cnt7");

    // out-of-range flow ids
    step(0, '0, 1);
    step(1, 64'h10);
    step(1, 64'h1_0000_0003);
    drain();
    rdchk(17, 2, 2, 2, "t4_miss");
    rdchk(0, 0, 0, 0, "t4_cnt0");
    rdchk(3, 0, 0, 0, "t4_cnt3");
    rdchk(16, 16, 16, 16, "t4_total");

    // saturation of 8-bit counters
    step(0, '0, 1);
    repeat (40) step(1, 64'd5);
    drain();
    rdchk(5, 320, 80, 255, "t5_cnt5");

    // start+stop together from DONE, then reset mid-run
    step(0, '0, 0, 1);
    chk("t6_done", longint'(done_m), 1);
    step(0, '0, 1, 1);
    chk("t6_running_main", longint'(run_m), 1);
    chk("t6_running_win", longint'(run_w), 1);
    rdchk(16, 0, 0, 0, "t6_total_cleared");
    repeat (5) step(1, 64'd2);
    repeat (3) step(0, '0);
    rst = 1'b0;
    #2;
    chk("t6_rst_running", longint'(run_m), 0);
    repeat (3) step(0, '0);
    rst = 1'b1;
    drain();
    rdchk(2, 0, 0, 0, "t6_rst_cnt2");
    rdchk(16, 0, 0, 0, "t6_rst_total");

    // randomized traffic with sporadic start/stop and readback
    step(0, '0, 1);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 7);
      if (r == 0)      d = {$urandom, $urandom};
      else if (r == 1) d = 64'($urandom_range(16, 8191));
      else             d = 64'($urandom_range(0, 15));
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 199) == 0, $urandom_range(0, 299) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 31));
    end
    drain();
    for (int s = 0; s < 18; s++) step(0, '0, 0, 0, 1, s);
    step(0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
